// File: rtl/wb_arb_pkg.sv
// Shared types and default bus widths for the Wishbone memory arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker for the non-priority requesters 1..N-1.
// Search starts at ptr and wraps from N-1 back to 1; index 0 is never picked.
//   req   : request bits for masters N-1..1
//   ptr   : first index to consider (1..N-1)
//   gnt   : one-hot winner, bit 0 always clear
//   valid : any request present
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:1]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  int idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N - 1; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - (N - 1);
      for (int i = 1; i < N; i++) begin
        if (!valid && (i == idx) && req[i]) begin
          gnt[i] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares one Wishbone B3 memory slave port between NUM_MASTERS requesters.
// Master 0 (display DMA) has fixed top priority, masters 1..N-1 rotate.
// The owner keeps the bus until it drops cyc; a watchdog aborts hung cycles.
//   clk, rst            : clock, async active-high reset
//   m_* (in)            : per-master request side, flattened by master index
//   m_ack/err/rty (out) : responses, only to the owner
//   m_dat_s2m (out)     : read data, broadcast
//   s_* (out/in)        : slave side
//   grant (out)         : one-hot owner, 0 when idle
//   timeout (out)       : one-cycle pulse on watchdog abort
//
// state | meaning
// IDLE  | bus free, arbitrate among m_cyc
// GRANT | owner's signals routed to the slave, watchdog running
// ABORT | one cycle: error to owner, bus released
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADR_W          = WB_ADR_W,
  parameter int DAT_W          = WB_DAT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MASTERS-1:0]       m_cyc,
  input  logic [NUM_MASTERS-1:0]       m_stb,
  input  logic [NUM_MASTERS-1:0]       m_we,
  input  logic [NUM_MASTERS*ADR_W-1:0] m_adr,
  input  logic [NUM_MASTERS*DAT_W-1:0] m_dat_m2s,
  input  logic [NUM_MASTERS*4-1:0]     m_sel,
  input  logic [NUM_MASTERS*3-1:0]     m_cti,
  input  logic [NUM_MASTERS*2-1:0]     m_bte,
  output logic [NUM_MASTERS-1:0]       m_ack,
  output logic [NUM_MASTERS-1:0]       m_err,
  output logic [NUM_MASTERS-1:0]       m_rty,
  output logic [DAT_W-1:0]             m_dat_s2m,
  output logic                       s_cyc,
  output logic                       s_stb,
  output logic                       s_we,
  output logic [ADR_W-1:0]           s_adr,
  output logic [DAT_W-1:0]           s_dat_m2s,
  output logic [3:0]                 s_sel,
  output logic [2:0]                 s_cti,
  output logic [1:0]                 s_bte,
  input  logic                       s_ack,
  input  logic                       s_err,
  input  logic                       s_rty,
  input  logic [DAT_W-1:0]           s_dat_s2m,
  output logic [NUM_MASTERS-1:0]       grant,
  output logic                       timeout
);

  localparam int N     = NUM_MASTERS;
  localparam int PTR_W = $clog2(N);
  // Width floors at 1 so a disabled watchdog still elaborates.
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  arb_state_t       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [N-1:0]     pick_gnt;
  logic             pick_valid;
  logic             resp;

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_rr_pick (
    .req   (m_cyc[N-1:1]),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign resp      = s_ack | s_err | s_rty;
  assign grant     = grant_q;
  assign m_dat_s2m = s_dat_s2m;

  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_m2s = '0;
    s_sel     = '0;
    s_cti     = '0;
    s_bte     = '0;
    m_ack     = '0;
    m_err     = '0;
    m_rty     = '0;
    timeout   = 1'b0;
    if (state_q == GRANT) begin
      for (int i = 0; i < N; i++) begin
        if (grant_q[i]) begin
          s_cyc     = m_cyc[i];
          s_stb     = m_stb[i];
          s_we      = m_we[i];
          s_adr     = m_adr[i*ADR_W +: ADR_W];
          s_dat_m2s = m_dat_m2s[i*DAT_W +: DAT_W];
          s_sel     = m_sel[i*4 +: 4];
          s_cti     = m_cti[i*3 +: 3];
          s_bte     = m_bte[i*2 +: 2];
        end
      end
      m_ack = grant_q & {N{s_ack}};
      m_err = grant_q & {N{s_err}};
      m_rty = grant_q & {N{s_rty}};
    end else if (state_q == ABORT) begin
      // Slave responses are ignored here; the owner only sees the abort error.
      m_err   = grant_q;
      timeout = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (m_cyc[0] || pick_valid) begin
          state_d = GRANT;
          if (m_cyc[0]) begin
            grant_d = N'(1);
          end else begin
            grant_d = pick_gnt;
            for (int i = 1; i < N; i++) begin
              if (pick_gnt[i]) rr_ptr_d = (i == N - 1) ? PTR_ONE : PTR_W'(i + 1);
            end
          end
        end
      end
      GRANT: begin
        if (!s_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (s_stb && !resp) begin
          if ((TIMEOUT_CYCLES > 0) && (wdog_q == WD_LAST)) state_d = ABORT;
          else if (wdog_q != '1)                           wdog_d  = wdog_q + 1'b1;
          else                                             wdog_d  = wdog_q;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_ONE;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

  localparam int NM = 3;
  localparam int BUDGET = 200;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  logic clk, rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we, m_ack, m_err, m_rty, grant;
  logic [NM*32-1:0] m_adr, m_dat_m2s;
  logic [NM*4-1:0]  m_sel;
  logic [NM*3-1:0]  m_cti;
  logic [NM*2-1:0]  m_bte;
  logic [31:0]      m_dat_s2m, s_adr, s_dat_m2s, s_dat_s2m;
  logic             s_cyc, s_stb, s_we, s_ack, s_err, s_rty, timeout;
  logic [3:0]       s_sel;
  logic [2:0]       s_cti;
  logic [1:0]       s_bte;

  logic        mcyc[NM], mstb[NM], mwe[NM];
  logic [31:0] madr[NM], mdat[NM];
  logic [3:0]  msel[NM];
  logic [2:0]  mcti[NM];
  logic [1:0]  mbte[NM];
  logic        slv_auto, slv_ack, slv_err, slv_rty;

  int   n_checks, n_fail;
  int   ord_q[$];
  exp_t exp_q[NM][$];

  wb_mem_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(16), .ADR_W(32), .DAT_W(32)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_m2s(m_dat_m2s),
    .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_s2m(m_dat_s2m),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m2s(s_dat_m2s),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_s2m(s_dat_s2m),
    .grant(grant), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_cyc[i]             = mcyc[i];
      m_stb[i]             = mstb[i];
      m_we[i]              = mwe[i];
      m_adr[i*32 +: 32]     = madr[i];
      m_dat_m2s[i*32 +: 32] = mdat[i];
      m_sel[i*4 +: 4]       = msel[i];
      m_cti[i*3 +: 3]       = mcti[i];
      m_bte[i*2 +: 2]       = mbte[i];
    end
  end

  // Slave model: read data is a fixed mix of everything the slave sees,
  // so a wrong request mux shows up as wrong data.
  function automatic logic [31:0] slv_f(input logic [31:0] adr, input logic [31:0] dat,
                                        input logic we, input logic [3:0] sel,
                                        input logic [2:0] cti, input logic [1:0] bte);
    return adr ^ {dat[31:12], we, sel, cti, bte, 2'b00};
  endfunction

  assign s_ack     = slv_auto ? (s_cyc & s_stb) : slv_ack;
  assign s_err     = slv_err;
  assign s_rty     = slv_rty;
  assign s_dat_s2m = slv_f(s_adr, s_dat_m2s, s_we, s_sel, s_cti, s_bte);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int m, input logic err);
    exp_t e;
    e.err = err;
    e.dat = slv_f(madr[m], mdat[m], mwe[m], msel[m], mcti[m], mbte[m]);
    exp_q[m].push_back(e);
  endtask

  task automatic master_xfer(input int m, input logic [31:0] adr, input int beats);
    bit stop;
    bit done;
    int n;
    stop = 1'b0;
    mcyc[m] = 1'b1;
    mstb[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      madr[m] = adr + 32'(4 * b);
      mcti[m] = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
      push_exp(m, 1'b0);
      done = 1'b0;
      n = 0;
      while (!done) begin
        @(negedge clk);
        if (rst) begin
          void'(exp_q[m].pop_back());
          stop = 1'b1;
          done = 1'b1;
        end else if (m_ack[m] || m_err[m]) begin
          done = 1'b1;
          if (m_err[m]) stop = 1'b1;
        end else if (n >= BUDGET) begin
          check("xfer_wait", m_ack[m] | m_err[m], 1);
          void'(exp_q[m].pop_back());
          stop = 1'b1;
          done = 1'b1;
        end
        n++;
      end
      cyc();
      if (stop) break;
    end
    mcyc[m] = 1'b0;
    mstb[m] = 1'b0;
    mcti[m] = 3'b000;
  endtask

  task automatic monitor();
    logic [NM-1:0] prev_g;
    exp_t e;
    int exp_m;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (grant != 0 && prev_g == 0) begin
          if (ord_q.size() == 0) check("grant_unexpected", grant, 0);
          else begin
            exp_m = ord_q.pop_front();
            check("grant_order", grant, 1 << exp_m);
          end
        end
        for (int m = 0; m < NM; m++) begin
          if (m_ack[m] || m_err[m]) begin
            if (exp_q[m].size() == 0) check("resp_unexpected", {m_ack[m], m_err[m]}, 0);
            else begin
              e = exp_q[m].pop_front();
              check("resp_kind", {m_ack[m], m_err[m]}, {~e.err, e.err});
              if (!e.err) check("rd_data", m_dat_s2m, e.dat);
            end
          end
        end
      end
      prev_g = grant;
    end
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    slv_auto = 1'b0; slv_ack = 1'b0; slv_err = 1'b0; slv_rty = 1'b0;
    for (int i = 0; i < NM; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; madr[i] = '0; mcti[i] = '0;
    end
    mdat[0] = 32'hA0A0_0001; mdat[1] = 32'hB1B1_0002; mdat[2] = 32'hC2C2_0003;
    msel[0] = 4'hF;          msel[1] = 4'h3;          msel[2] = 4'hC;
    mbte[0] = 2'd0;          mbte[1] = 2'd1;          mbte[2] = 2'd2;
    mwe[0]  = 1'b0;          mwe[1]  = 1'b0;          mwe[2]  = 1'b1;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) cyc();
    check("rst_outs", {s_cyc, s_stb, grant, m_ack, m_err, m_rty, timeout}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_grant", grant, 0);
    check("rst_rr_ptr", dut.rr_ptr_q, 1);

    // single read from m1, exact latency
    cyc();
    ord_q.push_back(1);
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h0100_0000; mcti[1] = 3'b000;
    push_exp(1, 1'b0);
    @(negedge clk);
    check("t1_grant_t0", grant, 0);
    check("t1_s_cyc_t0", s_cyc, 0);
    cyc();
    slv_ack = 1'b1;
    @(negedge clk);
    check("t1_grant", grant, 3'b010);
    check("t1_s_cyc", s_cyc, 1);
    check("t1_s_adr", s_adr, 32'h0100_0000);
    check("t1_m_ack", m_ack, 3'b010);
    cyc();
    slv_ack = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
    @(negedge clk);
    check("t1_drop_s_cyc", s_cyc, 0);
    check("t1_drop_grant", grant, 3'b010);
    cyc();
    @(negedge clk);
    check("t1_released", grant, 0);

    // rty and err routing to the owner only
    cyc();
    ord_q.push_back(1);
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h0000_0040;
    push_exp(1, 1'b1);
    cyc();
    slv_rty = 1'b1;
    @(negedge clk);
    check("t7_m_rty", m_rty, 3'b010);
    check("t7_no_ack", m_ack, 0);
    cyc();
    slv_rty = 1'b0; slv_err = 1'b1;
    @(negedge clk);
    check("t7_m_err", m_err, 3'b010);
    check("t7_no_timeout", timeout, 0);
    cyc();
    slv_err = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
    repeat (2) cyc();

    // m0 and m2 together: m0 first, m2 two cycles after m0 drops
    slv_auto = 1'b1;
    ord_q.push_back(0);
    ord_q.push_back(2);
    fork
      begin
        master_xfer(0, 32'h0000_1000, 2);
        @(negedge clk); check("t2_hold", grant, 3'b001);
        @(negedge clk); check("t2_dead", grant, 3'b000);
        @(negedge clk); check("t2_m2", grant, 3'b100);
      end
      master_xfer(2, 32'h0000_2000, 1);
    join
    repeat (3) cyc();

    // m1 and m2 continuous: strict alternation
    for (int k = 0; k < 3; k++) begin
      ord_q.push_back(1);
      ord_q.push_back(2);
    end
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          master_xfer(1, 32'h0001_0000 + 32'(k * 16), 1);
          cyc();
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          master_xfer(2, 32'h0002_0000 + 32'(k * 16), 1);
          cyc();
        end
      end
    join
    repeat (3) cyc();

    // m0 arrives during an m1 burst: no preemption
    ord_q.push_back(1);
    ord_q.push_back(0);
    fork
      begin
        master_xfer(1, 32'h0000_3000, 4);
        @(negedge clk); check("t4_hold", grant, 3'b010);
        @(negedge clk); check("t4_dead", grant, 3'b000);
        @(negedge clk); check("t4_m0", grant, 3'b001);
      end
      begin
        n = 0;
        while (grant != 3'b010 && n < BUDGET) begin
          @(negedge clk);
          n++;
        end
        check("t4_m1_granted", grant, 3'b010);
        cyc();
        master_xfer(0, 32'h0000_4000, 1);
      end
    join
    repeat (3) cyc();

    // watchdog abort after 16 unanswered stb cycles
    slv_auto = 1'b0;
    ord_q.push_back(1);
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h0000_5000;
    push_exp(1, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      @(negedge clk);
      check("t5_wait", {timeout, m_err, s_cyc}, 4'b0001);
    end
    cyc();
    @(negedge clk);
    check("t5_abort_timeout", timeout, 1);
    check("t5_abort_err", m_err, 3'b010);
    check("t5_abort_s_cyc", s_cyc, 0);
    cyc();
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    @(negedge clk);
    check("t5_after_timeout", timeout, 0);
    check("t5_after_grant", grant, 0);
    repeat (2) cyc();

    // ack on the 16th stb cycle beats the watchdog
    ord_q.push_back(2);
    mcyc[2] = 1'b1; mstb[2] = 1'b1; madr[2] = 32'h0000_6000;
    push_exp(2, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      cyc();
      @(negedge clk);
      check("t5b_wait", timeout, 0);
    end
    cyc();
    slv_ack = 1'b1;
    @(negedge clk);
    check("t5b_ack", m_ack, 3'b100);
    cyc();
    slv_ack = 1'b0; mcyc[2] = 1'b0; mstb[2] = 1'b0;
    @(negedge clk);
    check("t5b_no_abort", {timeout, m_err}, 0);
    repeat (2) cyc();

    // move rr_ptr off its reset value, then reset mid m0 burst
    slv_auto = 1'b1;
    ord_q.push_back(1);
    master_xfer(1, 32'h0000_7000, 1);
    cyc();
    ord_q.push_back(0);
    fork
      master_xfer(0, 32'h0800_0000, 800);
      begin
        repeat (300) cyc();
        rst = 1'b1;
        #2;
        check("t6_async", {s_cyc, grant, m_ack}, 0);
      end
    join
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rel_grant", grant, 0);
    check("t6_rel_s_cyc", s_cyc, 0);
    check("t6_rel_rr_ptr", dut.rr_ptr_q, 1);
    cyc();
    ord_q.push_back(1);
    ord_q.push_back(2);
    fork
      master_xfer(1, 32'h0000_8000, 1);
      master_xfer(2, 32'h0000_9000, 1);
    join
    repeat (3) cyc();

    check("ord_left", ord_q.size(), 0);
    for (int m = 0; m < NM; m++) check("exp_left", exp_q[m].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
